// File: rtl/twin_reg_cell.sv
// Single WIDTH-bit D register with synchronous, active-high reset to RST_VAL.
// One of these carries each channel of twin_reg.
module twin_reg_cell #(
    parameter int unsigned           WIDTH   = 8,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // The register loads on every edge, so the next state is simply the input.
    assign q_d = d;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/twin_reg.sv
// Two independent staging registers sharing one clock and one synchronous reset.
// Channel 1 carries d1 to q1 and channel 2 carries d2 to q2, each with one cycle of latency.
module twin_reg #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] RST_VAL1 = '0,
    parameter logic [WIDTH-1:0] RST_VAL2 = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2
);

    twin_reg_cell #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL1)
    ) u_ch1 (
        .clk (clk),
        .rst (rst),
        .d   (d1),
        .q   (q1)
    );

    twin_reg_cell #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL2)
    ) u_ch2 (
        .clk (clk),
        .rst (rst),
        .d   (d2),
        .q   (q2)
    );

endmodule

// File: tb/tb_twin_reg.sv
// Directed table-driven bench for twin_reg plus hand-written reset-timing sequences.
module tb_twin_reg;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] q1;
    logic [WIDTH-1:0] q2;

    int total;
    int bad;

    twin_reg #(
        .WIDTH    (WIDTH),
        .RST_VAL1 ('0),
        .RST_VAL2 ('0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .d1  (d1),
        .d2  (d2),
        .q1  (q1),
        .q2  (q2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic [WIDTH-1:0] d1;
        logic [WIDTH-1:0] d2;
        logic [WIDTH-1:0] exp_q1;
        logic [WIDTH-1:0] exp_q2;
        string            name;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        d1    = '0;
        d2    = '0;

        vecs[0] = '{1'b1, 8'd67,  8'd99, 8'd0,   8'd0,  "reset_edge1"};
        vecs[1] = '{1'b1, 8'd67,  8'd99, 8'd0,   8'd0,  "reset_edge2"};
        vecs[2] = '{1'b0, 8'd67,  8'd99, 8'd67,  8'd99, "load"};
        vecs[3] = '{1'b0, 8'd43,  8'd32, 8'd43,  8'd32, "update"};
        vecs[4] = '{1'b1, 8'd43,  8'd32, 8'd0,   8'd0,  "mid_reset"};
        vecs[5] = '{1'b0, 8'd255, 8'd1,  8'd255, 8'd1,  "post_reset_load"};
        vecs[6] = '{1'b0, 8'h00,  8'd32, 8'h00,  8'd32, "indep_a"};
        vecs[7] = '{1'b0, 8'hFF,  8'd32, 8'hFF,  8'd32, "indep_b"};
        vecs[8] = '{1'b0, 8'h00,  8'd32, 8'h00,  8'd32, "indep_c"};
        vecs[9] = '{1'b0, 8'hFF,  8'd32, 8'hFF,  8'd32, "indep_d"};

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            d1  = vecs[i].d1;
            d2  = vecs[i].d2;
            #1;
            // Outputs must still show the previous edge's result until the next posedge.
            if (i > 0) begin
                check({vecs[i].name, "_pre_q1"}, q1, vecs[i-1].exp_q1);
                check({vecs[i].name, "_pre_q2"}, q2, vecs[i-1].exp_q2);
            end
            @(posedge clk);
            #1;
            check({vecs[i].name, "_q1"}, q1, vecs[i].exp_q1);
            check({vecs[i].name, "_q2"}, q2, vecs[i].exp_q2);
        end

        // Reset pulse fully between two edges must not reset anything.
        @(negedge clk);
        d1  = 8'h5A;
        d2  = 8'hA5;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("glitch_q1", q1, 8'h5A);
        check("glitch_q2", q2, 8'hA5);

        // Reset raised mid-cycle takes effect only at the following edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("late_rst_pre_q1", q1, 8'h5A);
        check("late_rst_pre_q2", q2, 8'hA5);
        @(posedge clk);
        #1;
        check("late_rst_q1", q1, 8'h00);
        check("late_rst_q2", q2, 8'h00);

        // First edge after reset falls loads whatever d holds at that edge.
        @(negedge clk);
        rst = 1'b0;
        d1  = 8'h3C;
        d2  = 8'hC3;
        @(posedge clk);
        #1;
        check("release_q1", q1, 8'h3C);
        check("release_q2", q2, 8'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
